vm_prod_acc: RTL and testbench
==============================

# vm_prod_acc

Sequential accumulator stage downstream of the 4x4 Vedic multiplier (`VM_FA_xnor`). It consumes the 8-bit unsigned product stream through a valid/ready handshake and sums one packet of products, delimited by `in_last`. It then presents the packet total, term count and status flags on a held output handshake. Typical use is dot products and FIR taps built from the 4-bit multiplier array.

## Interface

Parameters:
- `ACC_W`, default 16: accumulator and result width in bits. Must be ≥ 8.
- `MAX_LEN`, default 16: maximum number of terms per packet. Must be ≥ 1.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  a product beat is present.
- `in_ready`  out  1  the block can accept a beat this cycle.
- `in_prod`  in  8  unsigned product `s[7:0]` from the multiplier.
- `in_last`  in  1  this beat closes the packet.
- `out_valid`  out  1  result is valid and held stable.
- `out_ready`  in  1  the consumer takes the result.
- `out_acc`  out  ACC_W  packet sum.
- `out_cnt`  out  $clog2(MAX_LEN+1)  number of terms accepted in the packet.
- `out_ovf`  out  1  sticky: at least one add in the packet carried out of ACC_W.
- `out_trunc`  out  1  the packet was force-closed at MAX_LEN without `in_last`.

## Operation

Handshakes:
- An input beat is accepted when `in_valid && in_ready`.
- An output transfer occurs when `out_valid && out_ready`.

State machine states:
- IDLE: accumulator empty, `in_ready=1`.
  - Accept with close → DONE.
  - Accept without close → ACC.
- ACC: `in_ready=1`.
  - Accept with close → DONE.
  - Otherwise stay in ACC.
- DONE: `in_ready=0`, `out_valid=1`, outputs frozen.
  - Output transfer → IDLE, with acc, cnt and flags cleared.

Close condition:
- A beat closes the packet when `in_last=1`, or when it is the MAX_LEN-th accepted beat.
- `out_trunc=1` only when the close was forced, i.e. the MAX_LEN-th beat had `in_last=0`.

Arithmetic:
- Per accepted beat: `acc_next = acc + zero_ext(in_prod)`, computed in ACC_W+1 bits.
- A carry into bit ACC_W sets `ovf`, which then stays set until the packet is consumed.
- `cnt` increments once per accepted beat.

While `in_valid=0`, state, acc and cnt hold. Idle cycles are allowed mid-packet.

Reset:
- Every output resets to 0, except `in_ready`, which resets to 1. State resets to IDLE.
- Reset asserted mid-packet or in DONE discards all partial or pending results; nothing is emitted.

## Timing

- Result latency: a closing beat accepted at edge t gives `out_valid=1` from cycle t+1.
- Throughput: one beat per cycle inside a packet.
- DONE adds at least one dead cycle between packets: `in_ready` returns to 1 in the cycle after the output transfer.
- Output stability: `out_acc`, `out_cnt`, `out_ovf` and `out_trunc` stay stable while `out_valid && !out_ready`.
- `in_ready` is a registered function of state only. It has no combinational path from `out_ready` or `in_valid`.
- A single-beat packet (`in_last` on the first beat) gives `out_cnt=1` and `out_acc=in_prod`.

## Configuration

`VM_PROD_ACC_SAT_EN` selects saturating or wrapping accumulation:
- Defined: on a carry out, the accumulator clamps to 2^ACC_W−1, `out_ovf` is set, and later adds keep it saturated.
- Undefined: the accumulator wraps modulo 2^ACC_W and `out_ovf` still reports the wrap.
- All other behaviour is identical in both modes.

## Structure

Package `vm_acc_pkg` holds:
- the state enum (IDLE, ACC, DONE);
- the default `ACC_W`/`MAX_LEN` constants;
- the `PROD_W=8` constant.

Sub-module `vm_acc_add` is the combinational ACC_W adder with carry-out and the optional saturation. It is the only place `VM_PROD_ACC_SAT_EN` is tested. The FSM, counter and output registers stay in `vm_prod_acc`.

## Test plan

- Basic packet: beats 3, 5, 225 (=15×15), the last with `in_last`, `out_ready=1` → `out_acc=233`, `out_cnt=3`, flags 0, `out_valid` one cycle after the last beat.
- Output backpressure: `out_ready=0` for 5 cycles in DONE → outputs stable and `in_ready=0` throughout; `out_ready=1` → `in_ready=1` the next cycle.
- Forced close: `MAX_LEN=4`, four beats of 10, none with `in_last` → `out_acc=40`, `out_cnt=4`, `out_trunc=1`.
- Overflow: `ACC_W=8`, beats 200 then 100 (last) → with the macro, `out_acc=255` and `out_ovf=1`; without it, `out_acc=44` and `out_ovf=1`.
- Gaps and single beat: `in_valid` toggling mid-packet → the sum counts accepted beats only. A single beat 7 with `in_last` → `out_acc=7`, `out_cnt=1`.
- Reset mid-packet: `rst` after two beats → no `out_valid`. The next packet, beat 9 (last), → `out_acc=9`, `out_cnt=1`.

Source files
------------

// File: rtl/vm_prod_acc_pkg.sv
// Shared definitions for the product accumulator slice.
// Holds the FSM state encoding, the default sizing constants and the
// product width coming out of the 4x4 Vedic multiplier.
package vm_acc_pkg;

    // Packet phases: waiting for the first beat, mid-packet, and result held.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_ACC_W   = 16;
    localparam int DEF_MAX_LEN = 16;
    localparam int PROD_W      = 8;

endpackage

// File: rtl/vm_prod_acc_if.sv
// Product-in / result-out handshake bundle for vm_prod_acc.
// The slave modport is the accumulator's view; the master modport is the
// view of whatever drives products in and consumes results.
interface vm_prod_acc_if #(
    parameter int ACC_W   = 16,
    parameter int MAX_LEN = 16
);
    localparam int CNT_W = $clog2(MAX_LEN + 1);

    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_prod;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_cnt;
    logic             out_ovf;
    logic             out_trunc;

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_cnt, out_ovf, out_trunc
    );

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_cnt, out_ovf, out_trunc
    );
endinterface

// File: rtl/vm_prod_acc_add.sv
// Combinational accumulator adder: acc + zero-extended product, with carry-out.
// Build option VM_PROD_ACC_SAT_EN: when defined the sum clamps to all-ones on
// a carry out; otherwise it wraps. The carry is reported in both modes.
module vm_acc_add
    import vm_acc_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [PROD_W-1:0] prod_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              carry_o
);

    logic [ACC_W:0] sumFull;

    // One extra bit catches the carry out of the accumulator width.
    always_comb begin
        sumFull = {1'b0, acc_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_i};
        carry_o = sumFull[ACC_W];
`ifdef VM_PROD_ACC_SAT_EN
        sum_o   = sumFull[ACC_W] ? {ACC_W{1'b1}} : sumFull[ACC_W-1:0];
`else
        sum_o   = sumFull[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/vm_prod_acc.sv
// Packet accumulator downstream of the 4x4 Vedic multiplier.
// Sums one in_last-delimited packet of 8-bit products (force-closed at
// MAX_LEN beats) and holds total, count and flags until consumed.
// Saturating vs wrapping sums follow VM_PROD_ACC_SAT_EN inside vm_acc_add.
module vm_prod_acc
    import vm_acc_pkg::*;
#(
    parameter int ACC_W   = DEF_ACC_W,
    parameter int MAX_LEN = DEF_MAX_LEN
) (
    input  logic        clk,
    input  logic        rst,
    vm_prod_acc_if.slave bus
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_LEN - 1);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             trunc_q, trunc_d;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [ACC_W-1:0] sum;
    logic             carry;
    logic             accept;
    logic             closeBeat;

    vm_acc_add #(.ACC_W(ACC_W)) u_add (
        .acc_i   (acc_q),
        .prod_i  (bus.in_prod),
        .sum_o   (sum),
        .carry_o (carry)
    );

    assign accept    = bus.in_valid && in_ready_q;
    assign closeBeat = bus.in_last || (cnt_q == LAST_IDX);

    // Next-state logic: fold accepted beats in, close on in_last or the
    // MAX_LEN-th beat, and clear everything once the result is taken.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        trunc_d = trunc_q;
        case (state_q)
            IDLE, ACC: begin
                if (accept) begin
                    acc_d = sum;
                    cnt_d = cnt_q + CNT_W'(1);
                    ovf_d = ovf_q | carry;
                    if (closeBeat) begin
                        state_d = DONE;
                        trunc_d = !bus.in_last;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    trunc_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and handshake registers; the handshake flags are
    // registered decodes of the next state so in_ready has no input path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            trunc_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            trunc_q     <= trunc_d;
            in_ready_q  <= (state_d != DONE);
            out_valid_q <= (state_d == DONE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = acc_q;
    assign bus.out_cnt   = cnt_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.out_trunc = trunc_q;

endmodule

// File: tb/tb_vm_prod_acc.sv
// Directed testbench for vm_prod_acc, built with ACC_W=8 and MAX_LEN=4 so
// overflow and forced close are reachable with short packets.
// Expected sums follow VM_PROD_ACC_SAT_EN when it is defined for the build.
module tb_vm_prod_acc;

    localparam int ACC_W   = 8;
    localparam int MAX_LEN = 4;
`ifdef VM_PROD_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        string          name;
        logic [3:0][7:0] prod;
        logic [3:0]     last;
        int             n;
        logic [31:0]    expAcc;
        logic [31:0]    expCnt;
        logic           expOvf;
        logic           expTrunc;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    vm_prod_acc_if #(.ACC_W(ACC_W), .MAX_LEN(MAX_LEN)) bus ();

    vm_prod_acc #(.ACC_W(ACC_W), .MAX_LEN(MAX_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] p, input logic l);
        bus.in_valid = v;
        bus.in_prod  = p;
        bus.in_last  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic takeResult(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput({tag, " out_valid after take"}, 32'(bus.out_valid), 32'd0);
        checkOutput({tag, " in_ready after take"}, 32'(bus.in_ready), 32'd1);
        checkOutput({tag, " acc cleared"}, 32'(bus.out_acc), 32'd0);
        checkOutput({tag, " cnt cleared"}, 32'(bus.out_cnt), 32'd0);
    endtask

    vec_t vecs[7];

    initial begin
        checks = 0;
        errors = 0;

        vecs[0] = '{"basic",     {8'd0,   8'd225, 8'd5,   8'd3},   4'b0100, 3, 32'd233, 32'd3, 1'b0, 1'b0};
        vecs[1] = '{"forced",    {8'd10,  8'd10,  8'd10,  8'd10},  4'b0000, 4, 32'd40,  32'd4, 1'b0, 1'b1};
        vecs[2] = '{"overflow",  {8'd0,   8'd0,   8'd100, 8'd200}, 4'b0010, 2, SAT ? 32'd255 : 32'd44, 32'd2, 1'b1, 1'b0};
        vecs[3] = '{"single",    {8'd0,   8'd0,   8'd0,   8'd7},   4'b0001, 1, 32'd7,   32'd1, 1'b0, 1'b0};
        vecs[4] = '{"maxlast",   {8'd255, 8'd255, 8'd255, 8'd255}, 4'b1000, 4, SAT ? 32'd255 : 32'd252, 32'd4, 1'b1, 1'b0};
        vecs[5] = '{"zeros",     {8'd0,   8'd0,   8'd0,   8'd0},   4'b0010, 2, 32'd0,   32'd2, 1'b0, 1'b0};
        vecs[6] = '{"fourlast",  {8'd4,   8'd3,   8'd2,   8'd1},   4'b1000, 4, 32'd10,  32'd4, 1'b0, 1'b0};

        bus.in_valid  = 1'b0;
        bus.in_prod   = 8'd0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset out_acc", 32'(bus.out_acc), 32'd0);
        checkOutput("reset out_cnt", 32'(bus.out_cnt), 32'd0);
        checkOutput("reset out_ovf", 32'(bus.out_ovf), 32'd0);
        checkOutput("reset out_trunc", 32'(bus.out_trunc), 32'd0);
        rst = 1'b0;

        // Table-driven packets: each result must appear one cycle after the
        // closing beat and clear one cycle after it is taken.
        for (int i = 0; i < 7; i++) begin
            for (int b = 0; b < vecs[i].n; b++) begin
                checkOutput({vecs[i].name, " in_ready"}, 32'(bus.in_ready), 32'd1);
                checkOutput({vecs[i].name, " no early out_valid"}, 32'(bus.out_valid), 32'd0);
                applyStimulus(1'b1, vecs[i].prod[b], vecs[i].last[b]);
            end
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
            checkOutput({vecs[i].name, " out_valid"}, 32'(bus.out_valid), 32'd1);
            checkOutput({vecs[i].name, " in_ready low"}, 32'(bus.in_ready), 32'd0);
            checkOutput({vecs[i].name, " out_acc"}, 32'(bus.out_acc), vecs[i].expAcc);
            checkOutput({vecs[i].name, " out_cnt"}, 32'(bus.out_cnt), vecs[i].expCnt);
            checkOutput({vecs[i].name, " out_ovf"}, 32'(bus.out_ovf), 32'(vecs[i].expOvf));
            checkOutput({vecs[i].name, " out_trunc"}, 32'(bus.out_trunc), 32'(vecs[i].expTrunc));
            takeResult(vecs[i].name);
        end

        // Backpressure: result held for 5 cycles while a stray beat is offered.
        applyStimulus(1'b1, 8'd1, 1'b0);
        applyStimulus(1'b1, 8'd2, 1'b1);
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.in_prod  = 8'd77;
            bus.in_last  = 1'b1;
            checkOutput("hold out_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("hold in_ready", 32'(bus.in_ready), 32'd0);
            checkOutput("hold out_acc", 32'(bus.out_acc), 32'd3);
            checkOutput("hold out_cnt", 32'(bus.out_cnt), 32'd2);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        takeResult("hold");

        // Gaps mid-packet: idle beats carry junk that must not be summed.
        applyStimulus(1'b1, 8'd4, 1'b0);
        applyStimulus(1'b0, 8'd99, 1'b0);
        applyStimulus(1'b1, 8'd6, 1'b0);
        applyStimulus(1'b0, 8'd99, 1'b1);
        applyStimulus(1'b0, 8'd99, 1'b0);
        checkOutput("gap still collecting", 32'(bus.out_valid), 32'd0);
        applyStimulus(1'b1, 8'd8, 1'b1);
        bus.in_valid = 1'b0;
        checkOutput("gap out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("gap out_acc", 32'(bus.out_acc), 32'd18);
        checkOutput("gap out_cnt", 32'(bus.out_cnt), 32'd3);
        takeResult("gap");

        // Reset mid-packet drops the partial sum; the next packet starts clean.
        applyStimulus(1'b1, 8'd50, 1'b0);
        applyStimulus(1'b1, 8'd60, 1'b0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rstmid out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rstmid out_acc", 32'(bus.out_acc), 32'd0);
        checkOutput("rstmid out_cnt", 32'(bus.out_cnt), 32'd0);
        checkOutput("rstmid in_ready", 32'(bus.in_ready), 32'd1);
        applyStimulus(1'b1, 8'd9, 1'b1);
        bus.in_valid = 1'b0;
        checkOutput("after rst out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("after rst out_acc", 32'(bus.out_acc), 32'd9);
        checkOutput("after rst out_cnt", 32'(bus.out_cnt), 32'd1);

        // Reset while a result is pending discards it.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rstdone out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rstdone in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rstdone out_acc", 32'(bus.out_acc), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
